ic74hc161_l: RTL and testbench



---
 rtl/ic74hc161_l.sv | 48 ++++
 tb/tb_ic74hc161_l.sv | 137 +++++++++++++
 2 files changed

// File: rtl/ic74hc161_l.sv
// Load-only 4-bit register in the style of a 74HC161 with the counter removed.
// Each stored bit is an independent slice with async clear and a sync load mux.

module ic74hc161_l_bit #(
    parameter logic CLR_BIT = 1'b0
) (
    input  logic clk,
    input  logic clr_n,
    input  logic load_n,
    input  logic d,
    output logic q
);

    // Clear wins over load at any edge and acts without a clock.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            q <= CLR_BIT;
        else if (!load_n)
            q <= d;
    end

endmodule

module ic74hc161_l #(
    parameter int                 WIDTH     = 4,
    parameter logic [WIDTH-1:0]   CLR_VALUE = '0
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load_n,
    output logic [WIDTH-1:0] out
);

    // out comes straight off the slice flops; no combinational path from inputs.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        ic74hc161_l_bit #(
            .CLR_BIT (CLR_VALUE[gi])
        ) u_bit (
            .clk    (clk),
            .clr_n  (clr_n),
            .load_n (load_n),
            .d      (in[gi]),
            .q      (out[gi])
        );
    end

endmodule

// File: tb/tb_ic74hc161_l.sv
module tb_ic74hc161_l;

  typedef struct {
    string      name;
    logic [3:0] exp;
    int         due;
  } exp_t;

  logic       clk = 1'b1;
  logic       clr_n;
  logic [3:0] in;
  logic       load_n;
  logic [3:0] out;

  exp_t q[$];
  int   negcnt = 0;
  int   nvec   = 0;
  int   nmis   = 0;

  ic74hc161_l #(.WIDTH(4), .CLR_VALUE(4'b0000)) dut (
    .clk    (clk),
    .clr_n  (clr_n),
    .in     (in),
    .load_n (load_n),
    .out    (out)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      negcnt++;
      while (q.size() != 0 && q[0].due <= negcnt) begin
        exp_t e;
        e = q.pop_front();
        nvec++;
        if (out !== e.exp) begin
          nmis++;
          $display("FAIL %s: out=%b expected=%b (negedge %0d)", e.name, out, e.exp, negcnt);
        end
      end
    end
  end

  task automatic push(input string nm, input logic [3:0] exp);
    exp_t e;
    e.name = nm;
    e.exp  = exp;
    e.due  = negcnt + 1;
    q.push_back(e);
  endtask

  task automatic drive(input logic clr, input logic ld, input logic [3:0] d,
                       input logic [3:0] exp, input string nm);
    @(negedge clk);
    #1;
    clr_n  = clr;
    load_n = ld;
    in     = d;
    push(nm, exp);
  endtask

  initial begin
    clr_n  = 1'b0;
    load_n = 1'b0;
    in     = 4'b0000;

    drive(1'b0, 1'b0, 4'b0000, 4'b0000, "init_clr");
    drive(1'b1, 1'b1, 4'b1010, 4'b0000, "hold_a");
    drive(1'b1, 1'b1, 4'b1010, 4'b0000, "hold_b");
    drive(1'b1, 1'b0, 4'b1010, 4'b1010, "load_a");
    drive(1'b1, 1'b1, 4'b1010, 4'b1010, "hold_load_a");
    drive(1'b1, 1'b1, 4'b0011, 4'b1010, "hold_in_change");
    drive(1'b1, 1'b0, 4'b0101, 4'b0101, "reload");
    drive(1'b1, 1'b1, 4'b0101, 4'b0101, "hold_reload");

    @(negedge clk);
    @(posedge clk);
    #2;
    clr_n = 1'b0;
    #1;
    nvec++;
    if (out !== 4'b0000) begin
      nmis++;
      $display("FAIL async_clr_immediate: out=%b expected=0000", out);
    end
    push("async_clr", 4'b0000);

    drive(1'b0, 1'b1, 4'b1111, 4'b0000, "clr_held");
    #1;
    nvec++;
    if (out !== 4'b0000) begin
      nmis++;
      $display("FAIL clr_held_immediate: out=%b expected=0000", out);
    end
    drive(1'b1, 1'b1, 4'b1111, 4'b0000, "release_hold");
    drive(1'b0, 1'b0, 4'b1111, 4'b0000, "clr_prio");
    drive(1'b1, 1'b0, 4'b1111, 4'b1111, "rel_load");
    drive(1'b1, 1'b0, 4'b0011, 4'b0011, "rep1");
    drive(1'b1, 1'b0, 4'b1100, 4'b1100, "rep2");
    drive(1'b1, 1'b0, 4'b1001, 4'b1001, "rep3");

    @(posedge clk);
    #2;
    in = 4'b0111;
    drive(1'b1, 1'b1, 4'b0111, 4'b1001, "hold_after_mid");

    repeat (2) @(negedge clk);
    #1;
    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      nvec++;
      nmis++;
      $display("FAIL %s: never checked, expected=%b", e.name, e.exp);
    end

    nvec++;
    if (out !== 4'b1001) begin
      nmis++;
      $display("FAIL final_hold: out=%b expected=1001", out);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    if (nmis == 0) $display("PASS");
    else           $display("FAIL %0d miscompares", nmis);
    $finish;
  end

  initial begin
    #5000;
    $display("FAIL watchdog: sim time exceeded, %0d entries pending", q.size());
    $fatal(1, "watchdog");
  end

endmodule
